// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 Set-2 movement decoder.
package kbd_pkg;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;
   typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/frame_req_latch.sv
// Holds a one-shot request until the next frame boundary; a new set beats the clear.
module frame_req_latch (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic startOfFrame,
   output logic req
);

   always_ff @(posedge clk) begin
      if (reset)
         req <= 1'b0;
      else if (set)
         req <= 1'b1;
      else if (startOfFrame)
         req <= 1'b0;
   end

endmodule

// File: rtl/kbd_move_decoder.sv
// Decodes PS/2 Set-2 scan bytes into per-frame left/right/shoot/start controls,
// with E0/F0 prefix handling, prefix timeout and last-pressed-wins direction.
module kbd_move_decoder
   import kbd_pkg::*;
#(
   parameter logic [7:0] SCAN_LEFT      = 8'h6B,
   parameter logic [7:0] SCAN_RIGHT     = 8'h74,
   parameter logic [7:0] SCAN_SHOOT     = 8'h29,
   parameter logic [7:0] SCAN_START     = 8'h5A,
   parameter int         PREFIX_TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scanByte,
   input  logic       scanValid,
   input  logic       startOfFrame,
   output logic       leftPress,
   output logic       rightPress,
   output logic       shootReq,
   output logic       startReq
);

   localparam int CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

   kbd_state_t       state;
   kbd_state_t       next_state;
   logic [CNT_W-1:0] tmo_cnt;

   logic is_key;
   logic is_make;
   logic is_ext;

   logic left_held;
   logic right_held;
   logic shoot_held;
   logic start_held;
   dir_t last_dir;

   // A key event is any byte that terminates a prefix sequence.
   always_comb begin
      next_state = state;
      is_key     = 1'b0;
      is_make    = 1'b0;
      is_ext     = 1'b0;
      if (scanValid) begin
         case (state)
            IDLE: begin
               if (scanByte == SC_EXT)
                  next_state = EXT;
               else if (scanByte == SC_BRK)
                  next_state = BRK;
               else begin
                  is_key  = 1'b1;
                  is_make = 1'b1;
               end
            end
            EXT: begin
               if (scanByte == SC_BRK)
                  next_state = EXT_BRK;
               else if (scanByte == SC_EXT)
                  next_state = EXT;
               else begin
                  is_key     = 1'b1;
                  is_make    = 1'b1;
                  is_ext     = 1'b1;
                  next_state = IDLE;
               end
            end
            BRK: begin
               is_key     = 1'b1;
               next_state = IDLE;
            end
            EXT_BRK: begin
               is_key     = 1'b1;
               is_ext     = 1'b1;
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   logic hit_left, hit_right, hit_shoot, hit_start;
   assign hit_left  = is_key &  is_ext & (scanByte == SCAN_LEFT);
   assign hit_right = is_key &  is_ext & (scanByte == SCAN_RIGHT);
   assign hit_shoot = is_key & !is_ext & (scanByte == SCAN_SHOOT);
   assign hit_start = is_key & !is_ext & (scanByte == SCAN_START);

   logic shoot_set, start_set;
   assign shoot_set = hit_shoot & is_make & !shoot_held;
   assign start_set = hit_start & is_make & !start_held;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tmo_cnt <= '0;
      end else if (scanValid) begin
         state   <= next_state;
         tmo_cnt <= '0;
      end else if (state != IDLE) begin
         if (tmo_cnt == CNT_LAST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
      end
   end

   // lastDir only moves on a fresh press so typematic repeats cannot steal priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         left_held  <= 1'b0;
         right_held <= 1'b0;
         shoot_held <= 1'b0;
         start_held <= 1'b0;
         last_dir   <= DIR_RIGHT;
         leftPress  <= 1'b0;
         rightPress <= 1'b0;
      end else begin
         if (hit_left) begin
            left_held <= is_make;
            if (is_make && !left_held)
               last_dir <= DIR_LEFT;
         end
         if (hit_right) begin
            right_held <= is_make;
            if (is_make && !right_held)
               last_dir <= DIR_RIGHT;
         end
         if (hit_shoot)
            shoot_held <= is_make;
         if (hit_start)
            start_held <= is_make;
         leftPress  <= left_held  & (!right_held | (last_dir == DIR_LEFT));
         rightPress <= right_held & (!left_held  | (last_dir == DIR_RIGHT));
      end
   end

   frame_req_latch u_shoot_req (
      .clk          (clk),
      .reset        (reset),
      .set          (shoot_set),
      .startOfFrame (startOfFrame),
      .req          (shootReq)
   );

   frame_req_latch u_start_req (
      .clk          (clk),
      .reset        (reset),
      .set          (start_set),
      .startOfFrame (startOfFrame),
      .req          (startReq)
   );

endmodule

// File: tb/tb_kbd_move_decoder.sv
// Directed vectors, hand-written corner sequences and a randomized run against a
// key-level reference model for kbd_move_decoder.
module tb_kbd_move_decoder;

   localparam int PT = 40;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scanByte = 8'h00;
   logic       scanValid = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       leftPress, rightPress, shootReq, startReq;
   logic [3:0] outs;

   assign outs = {leftPress, rightPress, shootReq, startReq};

   always #5 clk = ~clk;

   kbd_move_decoder #(.PREFIX_TIMEOUT(PT)) dut (
      .clk          (clk),
      .reset        (reset),
      .scanByte     (scanByte),
      .scanValid    (scanValid),
      .startOfFrame (startOfFrame),
      .leftPress    (leftPress),
      .rightPress   (rightPress),
      .shootReq     (shootReq),
      .startReq     (startReq)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: keys, a press-order queue for direction priority, prefix mode
   // with the edge number of the last prefix byte.
   bit       model_on = 1'b0;
   int       edge_no = 0;
   bit       m_ext, m_brk;
   int       pfx_edge;
   bit [3:0] held;           // 0 left, 1 right, 2 shoot, 3 start
   int       dq[$];          // held directions in press order, 0 left / 1 right
   bit       m_left, m_right, m_shoot, m_start;
   bit       set_shoot, set_start;

   task automatic key_event(input logic [7:0] b, input bit make, input bit extended);
      int k;
      k = -1;
      if (extended && b == 8'h6B) k = 0;
      if (extended && b == 8'h74) k = 1;
      if (!extended && b == 8'h29) k = 2;
      if (!extended && b == 8'h5A) k = 3;
      if (k < 0) return;
      if (make && !held[k]) begin
         held[k] = 1'b1;
         if (k < 2) dq.push_back(k);
         if (k == 2) set_shoot = 1'b1;
         if (k == 3) set_start = 1'b1;
      end else if (!make && held[k]) begin
         held[k] = 1'b0;
         foreach (dq[i]) if (dq[i] == k) begin dq.delete(i); break; end
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] b, input bit s, input bit r);
      edge_no++;
      if (r) begin
         m_ext = 0; m_brk = 0; held = '0; dq.delete();
         m_left = 0; m_right = 0; m_shoot = 0; m_start = 0;
         return;
      end
      m_left  = (dq.size() > 0) && (dq[dq.size()-1] == 0);
      m_right = (dq.size() > 0) && (dq[dq.size()-1] == 1);
      if ((m_ext || m_brk) && !v && (edge_no - pfx_edge >= PT)) begin
         m_ext = 0; m_brk = 0;
      end
      set_shoot = 0; set_start = 0;
      if (v) begin
         if (!m_ext && !m_brk && b == 8'hE0) begin m_ext = 1; pfx_edge = edge_no; end
         else if (!m_ext && !m_brk && b == 8'hF0) begin m_brk = 1; pfx_edge = edge_no; end
         else if (m_ext && !m_brk && b == 8'hE0) pfx_edge = edge_no;
         else if (m_ext && !m_brk && b == 8'hF0) begin m_brk = 1; pfx_edge = edge_no; end
         else begin
            key_event(b, !m_brk, m_ext);
            m_ext = 0; m_brk = 0;
         end
      end
      m_shoot = set_shoot ? 1'b1 : (s ? 1'b0 : m_shoot);
      m_start = set_start ? 1'b1 : (s ? 1'b0 : m_start);
   endtask

   task automatic cyc(input bit v, input logic [7:0] b, input bit s, input bit r);
      scanValid = v; scanByte = b; startOfFrame = s; reset = r;
      @(posedge clk);
      #1;
      scanValid = 1'b0; startOfFrame = 1'b0; reset = 1'b0;
      if (model_on) model_step(v, b, s, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   typedef struct packed {
      logic       v;
      logic [7:0] b;
      logic       s;
      logic [3:0] exp;   // {left, right, shoot, start} after the edge
   } vec_t;

   vec_t tbl[43];
   logic [7:0] pool[8];

   initial begin
      tbl[0]  = '{1'b1, 8'hE0, 1'b0, 4'b0000};
      tbl[1]  = '{1'b1, 8'h6B, 1'b0, 4'b0000};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 4'b1000};
      tbl[3]  = '{1'b1, 8'hE0, 1'b0, 4'b1000};
      tbl[4]  = '{1'b1, 8'hF0, 1'b0, 4'b1000};
      tbl[5]  = '{1'b1, 8'h6B, 1'b0, 4'b1000};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'b0000};
      tbl[7]  = '{1'b1, 8'hE0, 1'b0, 4'b0000};
      tbl[8]  = '{1'b1, 8'h74, 1'b0, 4'b0000};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'b0100};
      tbl[10] = '{1'b1, 8'hE0, 1'b0, 4'b0100};
      tbl[11] = '{1'b1, 8'h6B, 1'b0, 4'b0100};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 4'b1000};
      tbl[13] = '{1'b1, 8'hE0, 1'b0, 4'b1000};
      tbl[14] = '{1'b1, 8'hF0, 1'b0, 4'b1000};
      tbl[15] = '{1'b1, 8'h6B, 1'b0, 4'b1000};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 4'b0100};
      tbl[17] = '{1'b1, 8'hE0, 1'b0, 4'b0100};
      tbl[18] = '{1'b1, 8'hF0, 1'b0, 4'b0100};
      tbl[19] = '{1'b1, 8'h74, 1'b0, 4'b0100};
      tbl[20] = '{1'b0, 8'h00, 1'b0, 4'b0000};
      tbl[21] = '{1'b1, 8'h5A, 1'b1, 4'b0001};
      tbl[22] = '{1'b0, 8'h00, 1'b0, 4'b0001};
      tbl[23] = '{1'b0, 8'h00, 1'b1, 4'b0000};
      tbl[24] = '{1'b0, 8'h00, 1'b0, 4'b0000};
      tbl[25] = '{1'b1, 8'h29, 1'b0, 4'b0010};
      tbl[26] = '{1'b1, 8'hF0, 1'b0, 4'b0010};
      tbl[27] = '{1'b1, 8'h29, 1'b0, 4'b0010};
      tbl[28] = '{1'b0, 8'h00, 1'b1, 4'b0000};
      tbl[29] = '{1'b1, 8'h5A, 1'b0, 4'b0000};
      tbl[30] = '{1'b1, 8'hF0, 1'b0, 4'b0000};
      tbl[31] = '{1'b1, 8'h5A, 1'b0, 4'b0000};
      tbl[32] = '{1'b1, 8'h5A, 1'b0, 4'b0001};
      tbl[33] = '{1'b0, 8'h00, 1'b1, 4'b0000};
      tbl[34] = '{1'b1, 8'h6B, 1'b0, 4'b0000};
      tbl[35] = '{1'b0, 8'h00, 1'b0, 4'b0000};
      tbl[36] = '{1'b1, 8'hE0, 1'b0, 4'b0000};
      tbl[37] = '{1'b1, 8'h29, 1'b0, 4'b0000};
      tbl[38] = '{1'b0, 8'h00, 1'b0, 4'b0000};
      tbl[39] = '{1'b1, 8'hF0, 1'b0, 4'b0000};
      tbl[40] = '{1'b1, 8'h29, 1'b0, 4'b0000};
      tbl[41] = '{1'b1, 8'h29, 1'b0, 4'b0010};
      tbl[42] = '{1'b0, 8'h00, 1'b1, 4'b0000};

      pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h6B; pool[3] = 8'h74;
      pool[4] = 8'h29; pool[5] = 8'h5A; pool[6] = 8'h6B; pool[7] = 8'h74;

      // Reset state.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("reset_state", outs, 4'b0000);

      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].b, tbl[i].s, 1'b0);
         check($sformatf("vec%0d", i), outs, tbl[i].exp);
      end

      // Shoot typematic: only the first make raises the request.
      cyc(1'b1, 8'hF0, 1'b0, 1'b0);
      cyc(1'b1, 8'h29, 1'b0, 1'b0);
      check("shoot_break", outs, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 8'h29, 1'b0, 1'b0);
         check($sformatf("shoot_rep%0d", k), outs, 4'b0010);
         idle(99);
         check($sformatf("shoot_hold%0d", k), outs, 4'b0010);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("shoot_sof_clear", outs, 4'b0000);
      cyc(1'b1, 8'h29, 1'b0, 1'b0);
      check("shoot_typematic_no_set", outs, 4'b0000);

      // Prefix timeout: arrow after the timeout is dropped, shoot after it is accepted.
      cyc(1'b1, 8'hE0, 1'b0, 1'b0);
      idle(PT);
      cyc(1'b1, 8'h6B, 1'b0, 1'b0);
      idle(1);
      check("tmo_arrow_dropped", outs, 4'b0000);
      cyc(1'b1, 8'hF0, 1'b0, 1'b0);
      cyc(1'b1, 8'h29, 1'b0, 1'b0);
      cyc(1'b1, 8'hE0, 1'b0, 1'b0);
      idle(PT);
      cyc(1'b1, 8'h29, 1'b0, 1'b0);
      check("tmo_shoot_accepted", outs, 4'b0010);
      // Last cycle before the timeout still honours the prefix.
      cyc(1'b1, 8'hE0, 1'b0, 1'b0);
      idle(PT - 1);
      cyc(1'b1, 8'h6B, 1'b0, 1'b0);
      idle(1);
      check("tmo_boundary_left", outs, 4'b1010);

      // Reset in EXT_BRK with left held and shootReq pending.
      cyc(1'b1, 8'hE0, 1'b0, 1'b0);
      cyc(1'b1, 8'hF0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("reset_mid_ext_brk", outs, 4'b0000);
      cyc(1'b1, 8'h6B, 1'b0, 1'b0);
      idle(1);
      check("post_reset_6b_ignored", outs, 4'b0000);
      cyc(1'b1, 8'h29, 1'b0, 1'b0);
      check("post_reset_shoot", outs, 4'b0010);

      // Randomized run against the reference model.
      model_on = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("rand_reset", outs, {m_left, m_right, m_shoot, m_start});
      for (int n = 0; n < 3000; n++) begin
         bit         rv, rs, rr;
         logic [7:0] rb;
         rr = ($urandom_range(0, 499) == 0);
         rs = ($urandom_range(0, 19) == 0);
         rv = ($urandom_range(0, 2) == 0);
         rb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
         cyc(rv, rb, rs, rr);
         check("rand", outs, {m_left, m_right, m_shoot, m_start});
         if ($urandom_range(0, 59) == 0) begin
            int gap;
            gap = $urandom_range(PT - 3, PT + 3);
            for (int g = 0; g < gap; g++) begin
               cyc(1'b0, 8'h00, 1'b0, 1'b0);
               check("rand_gap", outs, {m_left, m_right, m_shoot, m_start});
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
